// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator. Two free-running
//               counters walk the (h,v) position through active area, front
//               porch, sync and back porch. Every other output is a register
//               loaded on the same edge as the counters from a decode of the
//               position being entered, so all outputs describe the current
//               position with zero latency relative to h_count/v_count.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock           in   pixel clock, all state changes on its rising edge
//   reset           in   asynchronous, active-high
//   clock_enable    in   advance one pixel position per enabled edge
//   restart         in   synchronous jump to (0,0) on next enabled edge
//   horizontal_sync out  HSYNC_POL level while h is in the sync region
//   vertical_sync   out  VSYNC_POL level while v is in the sync region
//   pixel_valid     out  high inside the active area
//   line_start      out  high at h==0
//   frame_start     out  high at h==0, v==0
//   vga_col         out  active-area column, 0 outside active area
//   vga_row         out  active-area row, 0 outside active area
//   h_count         out  raw horizontal position
//   v_count         out  raw vertical position
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  // Must be wide enough to hold max(H_TOTAL-1, V_TOTAL-1).
  parameter int COORD_W   = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clock_enable,
  input  logic               restart,
  output logic               horizontal_sync,
  output logic               vertical_sync,
  output logic               pixel_valid,
  output logic               line_start,
  output logic               frame_start,
  output logic [COORD_W-1:0] vga_col,
  output logic [COORD_W-1:0] vga_row,
  output logic [COORD_W-1:0] h_count,
  output logic [COORD_W-1:0] v_count
);

  // --------------------------------------------------------------------------
  // Derived timing constants
  // --------------------------------------------------------------------------
  localparam int C_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int C_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] c_zero      = '0;
  localparam logic [COORD_W-1:0] c_one       = COORD_W'(1);
  localparam logic [COORD_W-1:0] c_h_last    = COORD_W'(C_H_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_v_last    = COORD_W'(C_V_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_h_active  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] c_v_active  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] c_hs_start  = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0] c_hs_end    = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] c_vs_start  = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0] c_vs_end    = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

  // Asserted and idle levels of the two sync outputs.
  localparam logic c_hs_on  = (HSYNC_POL != 0);
  localparam logic c_hs_off = (HSYNC_POL == 0);
  localparam logic c_vs_on  = (VSYNC_POL != 0);
  localparam logic c_vs_off = (VSYNC_POL == 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_pixel_valid;
  logic               r_line_start;
  logic               r_frame_start;
  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;

  // --------------------------------------------------------------------------
  // Next-position logic
  // --------------------------------------------------------------------------
  logic [COORD_W-1:0] w_h_nxt;
  logic [COORD_W-1:0] w_v_nxt;
  logic               w_h_wrap;
  logic               w_v_wrap;

  assign w_h_wrap = (r_h == c_h_last);
  assign w_v_wrap = (r_v == c_v_last);

  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (restart) begin
      // Genlock: restart wins over normal advance.
      w_h_nxt = c_zero;
      w_v_nxt = c_zero;
    end else if (w_h_wrap) begin
      w_h_nxt = c_zero;
      w_v_nxt = w_v_wrap ? c_zero : (r_v + c_one);
    end else begin
      w_h_nxt = r_h + c_one;
    end
  end

  // --------------------------------------------------------------------------
  // Decode of the position being entered. Registering this decode alongside
  // the counters keeps outputs aligned with h_count/v_count and free of any
  // combinational path from the inputs.
  // --------------------------------------------------------------------------
  logic               w_h_in_active;
  logic               w_v_in_active;
  logic               w_pixel_valid;
  logic               w_h_in_sync;
  logic               w_v_in_sync;
  logic               w_line_start;
  logic               w_frame_start;
  logic [COORD_W-1:0] w_col;
  logic [COORD_W-1:0] w_row;

  assign w_h_in_active = (w_h_nxt < c_h_active);
  assign w_v_in_active = (w_v_nxt < c_v_active);
  assign w_pixel_valid = w_h_in_active && w_v_in_active;

  assign w_h_in_sync   = (w_h_nxt >= c_hs_start) && (w_h_nxt < c_hs_end);
  assign w_v_in_sync   = (w_v_nxt >= c_vs_start) && (w_v_nxt < c_vs_end);

  assign w_line_start  = (w_h_nxt == c_zero);
  assign w_frame_start = (w_h_nxt == c_zero) && (w_v_nxt == c_zero);

  // Coordinates are forced to zero outside the active area so a pixel source
  // can index its buffer without qualifying by pixel_valid.
  assign w_col = w_pixel_valid ? w_h_nxt : c_zero;
  assign w_row = w_pixel_valid ? w_v_nxt : c_zero;

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  // Reset parks the position on the last back-porch corner so that the first
  // enabled edge lands exactly on (0,0).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_h <= c_h_last;
      r_v <= c_v_last;
    end else if (clock_enable) begin
      r_h <= w_h_nxt;
      r_v <= w_v_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Registered decode outputs. With clock_enable low everything holds, so a
  // strobe stays asserted while the position is stalled on it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hsync       <= c_hs_off;
      r_vsync       <= c_vs_off;
      r_pixel_valid <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_col         <= c_zero;
      r_row         <= c_zero;
    end else if (clock_enable) begin
      r_hsync       <= w_h_in_sync ? c_hs_on : c_hs_off;
      r_vsync       <= w_v_in_sync ? c_vs_on : c_vs_off;
      r_pixel_valid <= w_pixel_valid;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      r_col         <= w_col;
      r_row         <= w_row;
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign horizontal_sync = r_hsync;
  assign vertical_sync   = r_vsync;
  assign pixel_valid     = r_pixel_valid;
  assign line_start      = r_line_start;
  assign frame_start     = r_frame_start;
  assign vga_col         = r_col;
  assign vga_row         = r_row;
  assign h_count         = r_h;
  assign v_count         = r_v;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen. Two instances run side
//               by side on shared stimulus: the default 640x480 timing and a
//               tiny 7x6 raster (H 4/1/1/1, V 3/1/1/1, active-high hsync) that
//               wraps many frames quickly. A reference model tracks the raster
//               position with plain arithmetic and pushes the expected output
//               set per clock; a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  // Configuration A (defaults)
  localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_HP = 0,   A_VP = 0,  A_W  = 10;
  // Configuration B (small)
  localparam int B_HA = 4, B_HF = 1, B_HS = 1, B_HB = 1;
  localparam int B_VA = 3, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_HP = 1, B_VP = 0, B_W  = 4;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic [31:0] col;
    logic [31:0] row;
    logic        hs;
    logic        vs;
    logic        pv;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic rs  = 1'b0;

  logic             a_hs, a_vs, a_pv, a_ls, a_fs;
  logic [A_W-1:0]   a_col, a_row, a_h, a_v;
  logic             b_hs, b_vs, b_pv, b_ls, b_fs;
  logic [B_W-1:0]   b_col, b_row, b_h, b_v;

  int compared   = 0;
  int mismatched = 0;

  item_t sb_q[$];

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clock(clk), .reset(rst), .clock_enable(en), .restart(rs),
    .horizontal_sync(a_hs), .vertical_sync(a_vs), .pixel_valid(a_pv),
    .line_start(a_ls), .frame_start(a_fs), .vga_col(a_col), .vga_row(a_row),
    .h_count(a_h), .v_count(a_v)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_ACTIVE(B_VA), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .HSYNC_POL(B_HP), .VSYNC_POL(B_VP), .COORD_W(B_W)
  ) u_dut_b (
    .clock(clk), .reset(rst), .clock_enable(en), .restart(rs),
    .horizontal_sync(b_hs), .vertical_sync(b_vs), .pixel_valid(b_pv),
    .line_start(b_ls), .frame_start(b_fs), .vga_col(b_col), .vga_row(b_row),
    .h_count(b_h), .v_count(b_v)
  );

  // --------------------------------------------------------------------------
  // Reference model: outputs as a direct function of the raster position.
  // --------------------------------------------------------------------------
  function automatic obs_t model_decode(int h, int v, int ha, int hf, int hsw,
                                        int va, int vf, int vsw, int hp, int vp);
    obs_t o;
    bit   valid;
    valid = (h < ha) && (v < va);
    o.h   = h;
    o.v   = v;
    o.pv  = valid;
    o.col = valid ? h : 0;
    o.row = valid ? v : 0;
    o.hs  = ((h >= ha + hf) && (h < ha + hf + hsw)) ? (hp != 0) : (hp == 0);
    o.vs  = ((v >= va + vf) && (v < va + vf + vsw)) ? (vp != 0) : (vp == 0);
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t model_reset(int htot, int vtot, int hp, int vp);
    obs_t o;
    o.h   = htot - 1;
    o.v   = vtot - 1;
    o.col = 0;
    o.row = 0;
    o.pv  = 1'b0;
    o.ls  = 1'b0;
    o.fs  = 1'b0;
    o.hs  = (hp == 0);
    o.vs  = (vp == 0);
    return o;
  endfunction

  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

  // Model state: absolute position plus "still showing reset values" flag.
  int ma_h, ma_v, mb_h, mb_v;
  bit m_in_reset;

  function automatic item_t model_expect();
    item_t it;
    if (m_in_reset) begin
      it.a = model_reset(A_HT, A_VT, A_HP, A_VP);
      it.b = model_reset(B_HT, B_VT, B_HP, B_VP);
    end else begin
      it.a = model_decode(ma_h, ma_v, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, A_HP, A_VP);
      it.b = model_decode(mb_h, mb_v, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, B_HP, B_VP);
    end
    return it;
  endfunction

  function automatic void model_reset_pos();
    ma_h = A_HT - 1; ma_v = A_VT - 1;
    mb_h = B_HT - 1; mb_v = B_VT - 1;
    m_in_reset = 1'b1;
  endfunction

  function automatic void model_edge(bit e, bit r);
    if (!e) return;
    m_in_reset = 1'b0;
    if (r) begin
      ma_h = 0; ma_v = 0; mb_h = 0; mb_v = 0;
    end else begin
      // Linear index within the frame, incremented modulo the frame size.
      int ia, ib;
      ia = (ma_v * A_HT + ma_h + 1) % (A_HT * A_VT);
      ib = (mb_v * B_HT + mb_h + 1) % (B_HT * B_VT);
      ma_h = ia % A_HT; ma_v = ia / A_HT;
      mb_h = ib % B_HT; mb_v = ib / B_HT;
    end
  endfunction

  // --------------------------------------------------------------------------
  // Observation and comparison
  // --------------------------------------------------------------------------
  function automatic item_t sample_dut();
    item_t it;
    it.a.h = 32'(a_h);   it.a.v = 32'(a_v);
    it.a.col = 32'(a_col); it.a.row = 32'(a_row);
    it.a.hs = a_hs; it.a.vs = a_vs; it.a.pv = a_pv; it.a.ls = a_ls; it.a.fs = a_fs;
    it.b.h = 32'(b_h);   it.b.v = 32'(b_v);
    it.b.col = 32'(b_col); it.b.row = 32'(b_row);
    it.b.hs = b_hs; it.b.vs = b_vs; it.b.pv = b_pv; it.b.ls = b_ls; it.b.fs = b_fs;
    return it;
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0t got h=%0d v=%0d col=%0d row=%0d hs=%b vs=%b pv=%b ls=%b fs=%b expected h=%0d v=%0d col=%0d row=%0d hs=%b vs=%b pv=%b ls=%b fs=%b",
               name, $time, act.h, act.v, act.col, act.row, act.hs, act.vs, act.pv, act.ls, act.fs,
               exp.h, exp.v, exp.col, exp.row, exp.hs, exp.vs, exp.pv, exp.ls, exp.fs);
    end
  endtask

  // Monitor: the DUT presents a new output set every cycle; compare away from
  // the active edge.
  initial begin
    item_t exp_it;
    item_t act_it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_it = sb_q.pop_front();
        act_it = sample_dut();
        check_obs("cfg_default", act_it.a, exp_it.a);
        check_obs("cfg_small", act_it.b, exp_it.b);
      end
    end
  end

  // One stimulus cycle: drive inputs just after a falling edge, predict the
  // state after the next rising edge and push it.
  task automatic drive(bit r_rst, bit r_en, bit r_rs);
    @(negedge clk);
    #1;
    rst = r_rst;
    en  = r_en;
    rs  = r_rs;
    if (r_rst) model_reset_pos();
    else       model_edge(r_en, r_rs);
    sb_q.push_back(model_expect());
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    item_t exp_it;
    model_reset_pos();

    // Reset held, with and without enable.
    for (int i = 0; i < 3; i++) drive(1'b1, i[0], 1'b0);

    // Free run: covers line 0 and the start of line 2 on the default raster
    // and dozens of frame wraps on the small one.
    for (int i = 0; i < 1700; i++) drive(1'b0, 1'b1, 1'b0);

    // Random enable with occasional restart (sometimes with enable low).
    for (int i = 0; i < 3000; i++)
      drive(1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 40) == 0));

    // Asynchronous reset mid-line, checked before any clock edge.
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset_pos();
    #2;
    exp_it = model_expect();
    check_obs("async_reset_default", sample_dut().a, exp_it.a);
    check_obs("async_reset_small", sample_dut().b, exp_it.b);

    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++)
      drive(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));

    // Drain the scoreboard.
    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain got %0d pending entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator; successor to the fixed 640x480 timing block. Produces hsync/vsync with configurable polarity, pixel_valid, active-area coordinates and line/frame start strobes, all from registered outputs. Horizontal and vertical porch/sync/active lengths are parameters. Adds clock-enable gating and a synchronous frame restart (genlock) input. Sits between the pixel clock domain and the pixel source / video DAC interface.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync (0 = active-low)
COORD_W, 10, width of coordinate/counter outputs; must hold max(H_TOTAL-1, V_TOTAL-1)

Ports:
clock  input  1  pixel clock, all state on rising edge
reset  input  1  asynchronous, active-high
clock_enable  input  1  advance one pixel position per enabled edge
restart  input  1  synchronous; jump to position (0,0) on next enabled edge
horizontal_sync  output  1  hsync at HSYNC_POL level during sync region
vertical_sync  output  1  vsync at VSYNC_POL level during sync region
pixel_valid  output  1  high when position is inside active area
line_start  output  1  one-position strobe at h=0 of every line
frame_start  output  1  one-position strobe at (h=0,v=0)
vga_col  output  COORD_W  active-area column; 0 when !pixel_valid
vga_row  output  COORD_W  active-area row; 0 when !pixel_valid
h_count  output  COORD_W  raw horizontal position
v_count  output  COORD_W  raw vertical position

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Line layout: active [0,H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], back porch. Vertical identical in lines.
- Position (h,v) held in h_count/v_count registers. All other outputs are registers loaded on the same edge from decode of the NEXT position, so every output always describes the current (h,v); zero latency relative to counters.
- Reset (async): h=H_TOTAL-1, v=V_TOTAL-1 (back porch corner); pixel_valid=0, line_start=0, frame_start=0, vga_col=vga_row=0, horizontal_sync=~HSYNC_POL, vertical_sync=~VSYNC_POL. First enabled edge after reset lands on (0,0).
- Advance (clock_enable=1, restart=0): h+1; if h=H_TOTAL-1 then h=0 and v+1; if also v=V_TOTAL-1 then v=0. Wrap-around is exact, no skipped or repeated position.
- clock_enable=0: all registers hold, including strobes (a strobe stays high while stalled on its position).
- restart=1 with clock_enable=1: next position (0,0) regardless of current position; frame_start and line_start asserted. restart with clock_enable=0 ignored (not latched).
- Priority: reset > restart > advance.
- pixel_valid = (h<H_ACTIVE)&&(v<V_ACTIVE). vga_col=h, vga_row=v when valid, else 0.
- horizontal_sync active when h in sync region, independent of v; vertical_sync active when v in sync region for all h of those lines.
- line_start = (h==0); frame_start = (h==0 && v==0).
- No state machine beyond the two counters; no combinational input-to-output paths.

Test Plan:
1. Defaults, reset, clock_enable=1 constant -> before edge 1: h=799, v=524, pixel_valid=0, syncs=1; edge 1: (0,0), frame_start=1, line_start=1, pixel_valid=1; edge 2: both strobes 0.
2. Line 0 sweep -> pixel_valid high edges 1..640 (vga_col 0..639), low from edge 641; horizontal_sync=0 exactly edges 657..752; line_start next at edge 801 with v_count=1.
3. Full frame -> vertical_sync=0 for v=490..491 (edges 392001..393600); frame_start again at edge 420001; vga_row 0..479 only while valid.
4. clock_enable toggled 1-0-1 randomly -> position sequence equals free-running sequence with stalls; strobes held during stalls.
5. restart pulsed at h=300,v=200 with enable high -> next edge (0,0), frame_start=1; restart with enable low -> ignored.
6. Reset asserted mid-line asynchronously (no clock edge) -> outputs immediately return to reset values; small config (H 4/1/1/1, V 3/1/1/1, HSYNC_POL=1) wraps at 7x6 with hsync=1 at h=5.
